flow_ctrl_unit: RTL
===================

// Module: flow_ctrl_unit
// PURPOSE
//  Program-flow executor on the consumer side of the ALU flag interface.
//  - Latches ALU zero/sign/carry into a status register.
//  - Resolves JMP/JZ/JS/JZS, LSR/XSR and TRAP ops issued by decode.
//  - Emits a one-cycle PC redirect to fetch; tracks trap entry/exit with a saved return PC (epc).
// PARAMETERS
//  ADDR_W       20        PC / target width
//  TRAP_VECTOR  20'h00010 redirect address on TRAP
// PORTS
//  clk             in   1       single clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  mode            in   1       1=full-word (20b), 0=half-word (10b)
//  op_valid        in   1       decode presents op
//  op_ready        out  1       op accepted when op_valid&op_ready
//  op_code         in   3       0 NOP,1 JMP,2 JZ,3 JS,4 JZS,5 LSR,6 XSR,7 TRAP
//  op_target       in   ADDR_W  jump target
//  op_imm          in   3       {carry,sign,zero} operand for LSR/XSR
//  pc_in           in   ADDR_W  PC of the presented op
//  flag_valid      in   1       ALU flags valid this cycle
//  alu_zero        in   1       ALU zero flag
//  alu_sign        in   1       ALU sign flag
//  alu_carry       in   1       ALU carry flag
//  trap_clear      in   1       return-from-trap request
//  redirect_valid  out  1       one-cycle pulse: fetch must load redirect_pc
//  redirect_pc     out  ADDR_W  new PC
//  status          out  4       {trap_active,carry,sign,zero}
//  epc             out  ADDR_W  saved return PC
//  taken_cnt       out  16      taken-branch count (see CONFIGURATION)
//  nottaken_cnt    out  16      not-taken count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): op_ready=1, redirect_valid=0, redirect_pc=0, status=0, epc=0, counters=0, state=IDLE.
//  Forwarding: F = flag_valid ? {alu_carry,alu_sign,alu_zero} : status[2:0].
//   - All conditions use F.
//   - flag_valid with no LSR/XSR accepted: status[2:0]<=F next edge.
//  Conditions: JMP always taken; JZ if F.zero; JS if F.sign; JZS if F.zero|F.sign.
//  LSR: status[2:0]<=op_imm. XSR: status[2:0]<=F^op_imm. Both override a same-cycle flag_valid.
//  Half-word mode (mode=0):
//   - redirect_pc[19:10]=0; target uses op_target[9:0].
//   - epc = {10'b0, pc_in[9:0]+1}, wrapping 10'h3FF->0.
//  Full-word (mode=1): epc = pc_in+1 mod 2^20 (20'hFFFFF->0).
//  FSM IDLE/REDIR:
//   - IDLE, taken jump accepted at edge N: REDIR; redirect_valid=1 and redirect_pc=target during cycle N+1 only.
//   - REDIR: op_ready=0; returns to IDLE at next edge. Not-taken/NOP/LSR/XSR stay IDLE, no pulse.
//   - Issue rate: 1 op/cycle without redirect; 1 op per 2 cycles with redirect.
//  TRAP, trap_active=0: epc<=pc_in+1 (mode rule), trap_active<=1, redirect to TRAP_VECTOR via REDIR.
//  TRAP, trap_active=1: treated as NOP; epc unchanged.
//  trap_clear, trap_active=1, IDLE:
//   - op_ready=0 that cycle (trap_clear wins over op_valid).
//   - Next edge: trap_active<=0; REDIR with redirect_pc=epc.
//  trap_clear when trap_active=0 or in REDIR: ignored.
//  Reset mid-REDIR: pulse dropped, FSM IDLE, epc/status lost.
// CONFIGURATION
//  FLOW_BRANCH_STATS_EN defined:
//   - taken_cnt/nottaken_cnt count accepted JZ/JS/JZS outcomes (JMP counts as taken).
//   - 16-bit, saturate at 16'hFFFF.
//  Undefined: both ports tied to 0; no counter flops.
// TESTING
//  1 flag_valid zero=1 with JZ target 20'h00ABC same cycle -> redirect_valid pulse next cycle, redirect_pc=20'h00ABC, status=4'b0001.
//  2 status=0, JZS target 20'h00100, flag_valid=0 -> no pulse, op_ready stays 1, nottaken_cnt=1 (macro on).
//  3 mode=0, TRAP at pc_in=20'h003FF -> epc=20'h00000, redirect_pc=20'h00010, status[3]=1; trap_clear -> redirect_pc=20'h00000.
//  4 XSR op_imm=3'b101 with flag_valid {c,s,z}=3'b001 -> status[2:0]=3'b100.
//  5 back-to-back JMPs held valid -> op_ready low in REDIR; 2nd accepted one cycle after 1st pulse.
//  6 rst_n low in REDIR -> redirect_valid=0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/flow_ctrl_unit_if.sv
// Interface: flow_ctrl_unit_if
// Purpose : bundles the decode-side op handshake, the ALU flag inputs and the
//           fetch redirect / status outputs of flow_ctrl_unit.
// Modports:
//   master - the decode/ALU/fetch side; drives mode, op_*, pc_in, flag_valid,
//            alu_*, trap_clear and observes the unit's outputs
//   slave  - flow_ctrl_unit itself
// Signals : mode, op_valid, op_ready, op_code[2:0], op_target[ADDR_W-1:0],
//           op_imm[2:0], pc_in[ADDR_W-1:0], flag_valid, alu_zero, alu_sign,
//           alu_carry, trap_clear, redirect_valid, redirect_pc[ADDR_W-1:0],
//           status[3:0], epc[ADDR_W-1:0], taken_cnt[15:0], nottaken_cnt[15:0]
interface flow_ctrl_unit_if #(
  parameter int ADDR_W = 20
);
  logic              mode;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [ADDR_W-1:0] op_target;
  logic [2:0]        op_imm;
  logic [ADDR_W-1:0] pc_in;
  logic              flag_valid;
  logic              alu_zero;
  logic              alu_sign;
  logic              alu_carry;
  logic              trap_clear;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [3:0]        status;
  logic [ADDR_W-1:0] epc;
  logic [15:0]       taken_cnt;
  logic [15:0]       nottaken_cnt;

  modport master (
    output mode, op_valid, op_code, op_target, op_imm, pc_in,
           flag_valid, alu_zero, alu_sign, alu_carry, trap_clear,
    input  op_ready, redirect_valid, redirect_pc, status, epc,
           taken_cnt, nottaken_cnt
  );

  modport slave (
    input  mode, op_valid, op_code, op_target, op_imm, pc_in,
           flag_valid, alu_zero, alu_sign, alu_carry, trap_clear,
    output op_ready, redirect_valid, redirect_pc, status, epc,
           taken_cnt, nottaken_cnt
  );
endinterface

// File: rtl/flow_ctrl_unit.sv
// Module : flow_ctrl_unit
// Purpose: program-flow executor. Latches ALU flags into a status register,
//          resolves JMP/JZ/JS/JZS, LSR/XSR and TRAP ops from decode, and emits a
//          one-cycle PC redirect to fetch. Tracks trap entry/exit with epc.
// Ports  :
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - flow_ctrl_unit_if.slave (op handshake, flags, redirect, status,
//           epc, branch counters)
// Config : FLOW_BRANCH_STATS_EN enables saturating taken/not-taken counters;
//          without it both counter outputs are tied to zero.
module flow_ctrl_unit #(
  parameter int                ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = 20'h00010
) (
  input  logic                 clk,
  input  logic                 rst_n,
  flow_ctrl_unit_if.slave      bus
);

  localparam int                HALF_W = ADDR_W / 2;
  localparam logic [ADDR_W-1:0] ONE_F  = 1;
  localparam logic [HALF_W-1:0] ONE_H  = 1;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_JMP  = 3'd1,
    OP_JZ   = 3'd2,
    OP_JS   = 3'd3,
    OP_JZS  = 3'd4,
    OP_LSR  = 3'd5,
    OP_XSR  = 3'd6,
    OP_TRAP = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_e;

  state_e            state;
  logic [2:0]        flags;
  logic              trap_active;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] epc;

  logic [2:0]        fwd;
  logic              accept;
  logic              is_branch;
  logic              taken;
  logic              trap_take;
  logic              clear_take;
  logic [ADDR_W-1:0] epc_next;
  op_e               op;

  // Half-word mode only exposes the low half of any address to fetch.
  function automatic logic [ADDR_W-1:0] fit_addr(input logic m,
                                                 input logic [ADDR_W-1:0] a);
    if (m) return a;
    return {{(ADDR_W-HALF_W){1'b0}}, a[HALF_W-1:0]};
  endfunction

  // A pending return-from-trap blocks the op handshake so the two cannot
  // both start a redirect in the same cycle.
  always_comb begin
    op         = op_e'(bus.op_code);
    fwd        = bus.flag_valid ? {bus.alu_carry, bus.alu_sign, bus.alu_zero}
                                : flags;
    clear_take = (state == IDLE) && bus.trap_clear && trap_active;
    bus.op_ready = (state == IDLE) && !(bus.trap_clear && trap_active);
    accept     = bus.op_valid && bus.op_ready;
    is_branch  = (op == OP_JMP) || (op == OP_JZ) || (op == OP_JS) ||
                 (op == OP_JZS);
    taken      = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = fwd[0];
      OP_JS:   taken = fwd[1];
      OP_JZS:  taken = fwd[0] | fwd[1];
      default: taken = 1'b0;
    endcase
    trap_take  = accept && (op == OP_TRAP) && !trap_active;
    epc_next   = bus.mode ? (bus.pc_in + ONE_F)
                          : {{(ADDR_W-HALF_W){1'b0}}, bus.pc_in[HALF_W-1:0] + ONE_H};
  end

  // Status flags, trap tracking and the IDLE/REDIR redirect sequencer.
  // LSR/XSR take priority over a same-cycle flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      flags          <= 3'b000;
      trap_active    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      epc            <= '0;
    end else begin
      redirect_valid <= 1'b0;

      if (accept && (op == OP_LSR))
        flags <= bus.op_imm;
      else if (accept && (op == OP_XSR))
        flags <= fwd ^ bus.op_imm;
      else if (bus.flag_valid)
        flags <= fwd;

      case (state)
        IDLE: begin
          if (clear_take) begin
            trap_active    <= 1'b0;
            state          <= REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= fit_addr(bus.mode, epc);
          end else if (accept && is_branch && taken) begin
            state          <= REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= fit_addr(bus.mode, bus.op_target);
          end else if (trap_take) begin
            epc            <= epc_next;
            trap_active    <= 1'b1;
            state          <= REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= fit_addr(bus.mode, TRAP_VECTOR);
          end
        end
        REDIR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.status         = {trap_active, flags};
  assign bus.epc            = epc;

`ifdef FLOW_BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;

  // Outcome counters for accepted branches; both stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt    <= 16'h0000;
      nottaken_cnt <= 16'h0000;
    end else if (accept && is_branch) begin
      if (taken) begin
        if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'h0001;
      end else begin
        if (nottaken_cnt != 16'hFFFF) nottaken_cnt <= nottaken_cnt + 16'h0001;
      end
    end
  end

  assign bus.taken_cnt    = taken_cnt;
  assign bus.nottaken_cnt = nottaken_cnt;
`else
  assign bus.taken_cnt    = 16'h0000;
  assign bus.nottaken_cnt = 16'h0000;
`endif

endmodule
